// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: FIFO-fed UART transmitter, 8N1 by default.
// Defining UART_TX_PARITY_EN adds an even-parity bit, which gives 8E1 frames.
package config_pkg;
   localparam int UartCmpVal = 173;
   localparam int FifoDataWidth = 8;
endpackage

module uart_tx_serializer #(
   parameter int CmpVal = config_pkg::UartCmpVal,
   parameter int DataWidth = config_pkg::FifoDataWidth
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DataWidth-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 tx,
   output logic                 busy
);
   localparam int CntW = $clog2(CmpVal);
   localparam int IdxW = DataWidth > 1 ? $clog2(DataWidth) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CmpVal - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(DataWidth - 1);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic parityBit;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t state;
   logic [CntW-1:0] cnt;
   logic [IdxW-1:0] idx;
   logic [DataWidth-1:0] shiftReg;
   logic [DataWidth-1:0] nextShift;
   logic bitEnd;
   assign bitEnd = cnt == CntLast;
   assign nextShift = shiftReg >> 1;
   assign busy = state != IDLE;
   assign in_ready = state == IDLE && reset;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         shiftReg <= '0;
         tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parityBit <= 1'b0;
`endif
      end else begin
         // every state change lands on a bit boundary, so one clear covers state entry too
         cnt <= (state == IDLE || bitEnd) ? '0 : cnt + 1'b1;
         case (state)
            IDLE: if (in_valid && in_ready) begin
               shiftReg <= in_data;
`ifdef UART_TX_PARITY_EN
               parityBit <= ^in_data;
`endif
               state <= START;
               tx <= 1'b0;
            end
            START: if (bitEnd) begin
               state <= DATA;
               tx <= shiftReg[0];
            end
            DATA: if (bitEnd) begin
               shiftReg <= nextShift;
               if (idx == IdxLast) begin
                  idx <= '0;
`ifdef UART_TX_PARITY_EN
                  state <= PARITY;
                  tx <= parityBit;
`else
                  state <= STOP;
                  tx <= 1'b1;
`endif
               end else begin
                  idx <= idx + 1'b1;
                  tx <= nextShift[0];
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bitEnd) begin
               state <= STOP;
               tx <= 1'b1;
            end
`endif
            STOP: if (bitEnd) begin
               state <= IDLE;
               tx <= 1'b1;
            end
            default: begin
               state <= IDLE;
               tx <= 1'b1;
            end
         endcase
      end
   end
endmodule
